// File: rtl/crc_pkg.sv
// Shared definitions for the streaming CRC engine: FSM encoding and the
// Ethernet CRC-32 constants used as parameter defaults.
package crc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_XOROUT  = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

  function automatic logic [31:0] reverse32(input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

endpackage

// File: rtl/crc_byte_step.sv
// Combinational single-byte CRC update; bit order selected by REFLECT.
module crc_byte_step
  import crc_pkg::*;
#(
  parameter logic [31:0] POLY    = CRC32_POLY,
  parameter int          REFLECT = 1
) (
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  localparam logic [31:0] POLY_REV = reverse32(POLY);

  always_comb begin
    crc_out = crc_in;
    if (REFLECT != 0) begin
      // LSB-first: the byte enters at the bottom and the register shifts right
      crc_out[7:0] = crc_in[7:0] ^ data;
      for (int i = 0; i < 8; i++)
        crc_out = crc_out[0] ? ((crc_out >> 1) ^ POLY_REV) : (crc_out >> 1);
    end else begin
      crc_out[31:24] = crc_in[31:24] ^ data;
      for (int i = 0; i < 8; i++)
        crc_out = crc_out[31] ? ((crc_out << 1) ^ POLY) : (crc_out << 1);
    end
  end

endmodule

// File: rtl/crc_stream_engine.sv
// Streaming CRC generator/checker: folds up to DATA_BYTES bytes per beat and
// reports one result per frame, one cycle after the last beat.
module crc_stream_engine
  import crc_pkg::*;
#(
  parameter int          DATA_BYTES = 1,
  parameter logic [31:0] POLY       = CRC32_POLY,
  parameter logic [31:0] INIT       = CRC32_INIT,
  parameter logic [31:0] XOROUT     = CRC32_XOROUT,
  parameter int          REFLECT    = 1,
  parameter logic [31:0] RESIDUE    = CRC32_RESIDUE
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [8*DATA_BYTES-1:0] s_data,
  input  logic [DATA_BYTES-1:0]   s_keep,
  input  logic                    s_last,
  input  logic                    s_abort,
  input  logic                    mode,
  output logic                    res_valid,
  output logic [31:0]             res_crc,
  output logic                    res_ok,
  output logic                    busy
);

  state_t      state, state_next;
  logic [31:0] crc_p0;
  logic        mode_p0;
  logic [31:0] res_crc_p1;
  logic        res_ok_p1;
  logic        accept, abort_hit, fold_en, frame_mode;
  logic [31:0] seed, crc_fold;

  assign s_ready    = !rst && (state != DONE);
  assign accept     = s_valid && s_ready;
  assign abort_hit  = s_abort && (state == RUN);
  assign fold_en    = accept && !abort_hit;
  assign seed       = (state == IDLE) ? INIT : crc_p0;
  assign frame_mode = (state == IDLE) ? mode : mode_p0;

  // Byte chain: a lane is folded only while every lower keep bit is also set
  for (genvar g = 0; g < DATA_BYTES; g++) begin : g_step
    logic [31:0] lane_in, stepped, lane_out;
    logic        keep_ok;
    if (g == 0) begin : g_first
      assign lane_in = seed;
      assign keep_ok = s_keep[0];
    end else begin : g_next
      assign lane_in = g_step[g-1].lane_out;
      assign keep_ok = g_step[g-1].keep_ok & s_keep[g];
    end
    crc_byte_step #(.POLY(POLY), .REFLECT(REFLECT)) u_step (
      .crc_in (lane_in),
      .data   (s_data[8*g +: 8]),
      .crc_out(stepped)
    );
    assign lane_out = keep_ok ? stepped : lane_in;
  end
  assign crc_fold = g_step[DATA_BYTES-1].lane_out;

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (accept) state_next = s_last ? DONE : RUN;
      RUN: begin
        if (s_abort)               state_next = IDLE;
        else if (accept && s_last) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Stage p0: running register; stage p1: result captured with the last beat
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      crc_p0     <= INIT;
      mode_p0    <= 1'b0;
      res_crc_p1 <= '0;
      res_ok_p1  <= 1'b0;
    end else begin
      state <= state_next;
      if (fold_en) begin
        crc_p0 <= crc_fold;
        if (state == IDLE) mode_p0 <= mode;
        if (s_last) begin
          res_crc_p1 <= crc_fold ^ XOROUT;
          res_ok_p1  <= frame_mode && (crc_fold == RESIDUE);
        end
      end
    end
  end

  assign res_valid = !rst && (state == DONE);
  assign busy      = !rst && (state != IDLE);
  assign res_crc   = res_crc_p1;
  assign res_ok    = res_ok_p1;

endmodule

// File: tb/tb_crc_stream_engine.sv
// Self-checking bench for crc_stream_engine: scoreboard on the 1-byte instance,
// inline checks on the 4-byte and MPEG-2 (non-reflected) instances.
module tb_crc_stream_engine;

  typedef struct packed {
    logic [31:0] crc;
    logic        ok;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        a_valid, a_last, a_abort, a_mode;
  logic [7:0]  a_data;
  logic [0:0]  a_keep;
  logic        a_ready, a_res_valid, a_res_ok, a_busy;
  logic [31:0] a_res_crc;

  logic        b_valid, b_last, b_abort, b_mode;
  logic [31:0] b_data;
  logic [3:0]  b_keep;
  logic        b_ready, b_res_valid, b_res_ok, b_busy;
  logic [31:0] b_res_crc;

  logic        c_valid, c_last, c_abort, c_mode;
  logic [7:0]  c_data;
  logic [0:0]  c_keep;
  logic        c_ready, c_res_valid, c_res_ok, c_busy;
  logic [31:0] c_res_crc;

  crc_stream_engine #(.DATA_BYTES(1)) dut_a (
    .clk(clk), .rst(rst), .s_valid(a_valid), .s_ready(a_ready), .s_data(a_data),
    .s_keep(a_keep), .s_last(a_last), .s_abort(a_abort), .mode(a_mode),
    .res_valid(a_res_valid), .res_crc(a_res_crc), .res_ok(a_res_ok), .busy(a_busy)
  );

  crc_stream_engine #(.DATA_BYTES(4)) dut_b (
    .clk(clk), .rst(rst), .s_valid(b_valid), .s_ready(b_ready), .s_data(b_data),
    .s_keep(b_keep), .s_last(b_last), .s_abort(b_abort), .mode(b_mode),
    .res_valid(b_res_valid), .res_crc(b_res_crc), .res_ok(b_res_ok), .busy(b_busy)
  );

  crc_stream_engine #(.DATA_BYTES(1), .REFLECT(0), .XOROUT(32'h0)) dut_c (
    .clk(clk), .rst(rst), .s_valid(c_valid), .s_ready(c_ready), .s_data(c_data),
    .s_keep(c_keep), .s_last(c_last), .s_abort(c_abort), .mode(c_mode),
    .res_valid(c_res_valid), .res_crc(c_res_crc), .res_ok(c_res_ok), .busy(c_busy)
  );

  int   n_checks = 0;
  int   n_pass   = 0;
  int   a_results = 0;
  int   a_stall   = 0;
  exp_t sb[$];
  exp_t mon_e;

  logic [7:0] msg[$] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

  // Reference: reflected CRC-32 register (before XOROUT), bit-serial
  function automatic logic [31:0] model_reg(input logic [7:0] b[$]);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (b[i]) begin
      c = c ^ {24'h0, b[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  always @(negedge clk) begin
    if (!rst && a_valid && !a_ready) a_stall++;
    if (a_res_valid) begin
      a_results++;
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL a_unexpected_result: got crc=%h ok=%b, no result expected", a_res_crc, a_res_ok);
      end else begin
        mon_e = sb.pop_front();
        if (a_res_crc !== mon_e.crc || a_res_ok !== mon_e.ok)
          $display("FAIL a_result: got crc=%h ok=%b want crc=%h ok=%b", a_res_crc, a_res_ok, mon_e.crc, mon_e.ok);
        else n_pass++;
      end
    end
  end

  task automatic a_beat(input logic [7:0] d, input logic k, input logic last, input logic m);
    int guard;
    a_valid = 1'b1; a_data = d; a_keep = k; a_last = last; a_mode = m;
    guard = 0;
    @(negedge clk);
    while (!a_ready && guard < 16) begin guard++; @(negedge clk); end
    n_checks++;
    if (a_ready !== 1'b1) $display("FAIL a_beat_ready: got %b want 1", a_ready); else n_pass++;
    @(posedge clk); #1;
  endtask

  // Mode is driven only on the first beat; later beats carry the opposite value
  task automatic a_frame(input logic [7:0] bytes[$], input logic m, input exp_t e);
    sb.push_back(e);
    foreach (bytes[i]) a_beat(bytes[i], 1'b1, (i == bytes.size() - 1), (i == 0) ? m : ~m);
  endtask

  task automatic b_beat(input logic [31:0] d, input logic [3:0] k, input logic last);
    b_valid = 1'b1; b_data = d; b_keep = k; b_last = last; b_mode = 1'b0;
    @(negedge clk);
    n_checks++;
    if (b_ready !== 1'b1) $display("FAIL b_beat_ready: got %b want 1", b_ready); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; a_valid = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (a_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", a_ready); else n_pass++;
    n_checks++; if (a_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", a_busy); else n_pass++;
    n_checks++; if (a_res_valid !== 1'b0) $display("FAIL reset_res_valid: got %b want 0", a_res_valid); else n_pass++;
    n_checks++; if (a_res_crc !== 32'h0) $display("FAIL reset_res_crc: got %h want 00000000", a_res_crc); else n_pass++;
    n_checks++; if (a_res_ok !== 1'b0) $display("FAIL reset_res_ok: got %b want 0", a_res_ok); else n_pass++;
    n_checks++; if (b_ready !== 1'b0) $display("FAIL reset_b_ready: got %b want 0", b_ready); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0; a_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (a_ready !== 1'b1) $display("FAIL post_reset_ready: got %b want 1", a_ready); else n_pass++;
    n_checks++; if (a_busy !== 1'b0) $display("FAIL post_reset_busy: got %b want 0", a_busy); else n_pass++;
  endtask

  task automatic test_generate();
    @(posedge clk); #1;
    a_frame(msg, 1'b0, '{crc: 32'hCBF43926, ok: 1'b0});
    a_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (a_res_valid !== 1'b1) $display("FAIL gen_latency: res_valid got %b want 1", a_res_valid); else n_pass++;
    n_checks++; if (a_busy !== 1'b1) $display("FAIL gen_busy_done: got %b want 1", a_busy); else n_pass++;
    @(negedge clk);
    n_checks++; if (a_res_valid !== 1'b0) $display("FAIL gen_one_cycle: res_valid got %b want 0", a_res_valid); else n_pass++;
    n_checks++; if (a_res_crc !== 32'hCBF43926) $display("FAIL gen_hold: res_crc got %h want cbf43926", a_res_crc); else n_pass++;
    n_checks++; if (a_busy !== 1'b0) $display("FAIL gen_busy_idle: got %b want 0", a_busy); else n_pass++;
  endtask

  task automatic test_check();
    logic [7:0]  chk[$];
    logic [7:0]  bad[$];
    logic [31:0] r;
    int          idx, bpos;
    chk = msg;
    chk.push_back(8'h26); chk.push_back(8'h39); chk.push_back(8'hF4); chk.push_back(8'hCB);
    @(posedge clk); #1;
    a_frame(chk, 1'b1, '{crc: 32'h2144DF1C, ok: 1'b1});
    a_valid = 1'b0;
    repeat (2) @(negedge clk);
    for (int n = 0; n < 3; n++) begin
      bad  = chk;
      idx  = $urandom_range(0, 12);
      bpos = $urandom_range(0, 7);
      bad[idx] = bad[idx] ^ (8'h01 << bpos);
      r = model_reg(bad);
      @(posedge clk); #1;
      a_frame(bad, 1'b1, '{crc: r ^ 32'hFFFFFFFF, ok: 1'b0});
      a_valid = 1'b0;
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic test_abort_reset();
    int n0;
    n0 = a_results;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) a_beat(msg[i], 1'b1, 1'b0, 1'b0);
    a_abort = 1'b1;
    a_beat(msg[3], 1'b1, 1'b1, 1'b0);
    a_abort = 1'b0; a_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (a_busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", a_busy); else n_pass++;
    @(posedge clk); #1;
    a_beat(msg[0], 1'b1, 1'b0, 1'b0);
    a_beat(msg[1], 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (a_ready !== 1'b0) $display("FAIL midrst_ready: got %b want 0", a_ready); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0; a_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (a_ready !== 1'b1) $display("FAIL midrst_after_ready: got %b want 1", a_ready); else n_pass++;
    @(posedge clk); #1;
    // Abort asserted in IDLE must not stop the first beat being taken
    sb.push_back('{crc: 32'hCBF43926, ok: 1'b0});
    a_abort = 1'b1;
    a_beat(msg[0], 1'b1, 1'b0, 1'b0);
    a_abort = 1'b0;
    for (int i = 1; i < 9; i++) a_beat(msg[i], 1'b1, (i == 8), 1'b1);
    a_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (a_results !== n0 + 1) $display("FAIL abort_result_count: got %0d want %0d", a_results - n0, 1); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] abc[$];
    abc = '{8'h41, 8'h42, 8'h43};
    @(posedge clk); #1;
    a_stall = 0;
    a_frame(msg, 1'b0, '{crc: 32'hCBF43926, ok: 1'b0});
    sb.push_back('{crc: model_reg(abc) ^ 32'hFFFFFFFF, ok: 1'b0});
    a_beat(8'h41, 1'b1, 1'b0, 1'b0);
    a_beat(8'hFF, 1'b0, 1'b0, 1'b0);
    a_beat(8'h42, 1'b1, 1'b0, 1'b0);
    a_beat(8'h43, 1'b1, 1'b0, 1'b0);
    a_beat(8'hEE, 1'b0, 1'b1, 1'b0);
    // A frame made only of an empty last beat leaves INIT, so INIT^XOROUT = 0
    sb.push_back('{crc: 32'h0, ok: 1'b0});
    a_beat(8'h55, 1'b0, 1'b1, 1'b0);
    n_checks++; if (a_stall !== 2) $display("FAIL b2b_stall_cycles: got %0d want 2", a_stall); else n_pass++;
    a_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_wide();
    @(posedge clk); #1;
    b_beat(32'h34333231, 4'hF, 1'b0);
    b_beat(32'h38373635, 4'hF, 1'b0);
    b_beat(32'h00000039, 4'b0001, 1'b1);
    b_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (b_res_valid !== 1'b1) $display("FAIL wide_latency: res_valid got %b want 1", b_res_valid); else n_pass++;
    n_checks++; if (b_res_crc !== 32'hCBF43926) $display("FAIL wide_crc: got %h want cbf43926", b_res_crc); else n_pass++;
    n_checks++; if (b_busy !== 1'b1) $display("FAIL wide_busy: got %b want 1", b_busy); else n_pass++;
    @(posedge clk); #1;
    // keep 1011 stops at the first zero: only "12" is folded from that beat
    b_beat(32'h34333231, 4'b1011, 1'b0);
    b_beat(32'h36353433, 4'hF, 1'b0);
    b_beat(32'h00393837, 4'b0111, 1'b1);
    b_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (b_res_valid !== 1'b1) $display("FAIL wide_gap_latency: res_valid got %b want 1", b_res_valid); else n_pass++;
    n_checks++; if (b_res_crc !== 32'hCBF43926) $display("FAIL wide_gap_crc: got %h want cbf43926", b_res_crc); else n_pass++;
    n_checks++; if (b_res_ok !== 1'b0) $display("FAIL wide_ok: got %b want 0", b_res_ok); else n_pass++;
  endtask

  task automatic test_mpeg();
    @(posedge clk); #1;
    for (int i = 0; i < 9; i++) begin
      c_valid = 1'b1; c_data = msg[i]; c_keep = 1'b1; c_last = (i == 8); c_mode = 1'b0;
      @(posedge clk); #1;
    end
    c_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (c_res_valid !== 1'b1) $display("FAIL mpeg_latency: res_valid got %b want 1", c_res_valid); else n_pass++;
    n_checks++; if (c_res_crc !== 32'h0376E6E7) $display("FAIL mpeg_crc: got %h want 0376e6e7", c_res_crc); else n_pass++;
    n_checks++; if (c_res_ok !== 1'b0 || c_busy !== 1'b1) $display("FAIL mpeg_ok_busy: got ok=%b busy=%b want 0/1", c_res_ok, c_busy); else n_pass++;
  endtask

  initial begin
    a_valid = 1'b0; a_last = 1'b0; a_abort = 1'b0; a_mode = 1'b0; a_data = '0; a_keep = '0;
    b_valid = 1'b0; b_last = 1'b0; b_abort = 1'b0; b_mode = 1'b0; b_data = '0; b_keep = '0;
    c_valid = 1'b0; c_last = 1'b0; c_abort = 1'b0; c_mode = 1'b0; c_data = '0; c_keep = '0;
    test_reset();
    test_generate();
    test_check();
    test_abort_reset();
    test_back_to_back();
    test_wide();
    test_mpeg();
    @(posedge clk); #1;
    n_checks++;
    if (sb.size() != 0) $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule

// File: doc/crc_stream_engine.md
CRC_STREAM_ENGINE -- requirements
Module: crc_stream_engine

Interface
REQ-001 SHALL have parameter DATA_BYTES, default 1, bytes per beat (legal 1, 2, 4, 8).
REQ-002 SHALL have parameter POLY, default 32'h04C11DB7, normal-form generator polynomial.
REQ-003 SHALL have parameter INIT, default 32'hFFFFFFFF, CRC register value at frame start.
REQ-004 SHALL have parameter XOROUT, default 32'hFFFFFFFF, XOR applied to the result.
REQ-005 SHALL have parameter REFLECT, default 1; 1 = LSB-first shift-right using bit-reversed POLY, 0 = MSB-first shift-left.
REQ-006 SHALL have parameter RESIDUE, default 32'hDEBB20E3, internal register value that indicates a good frame in check mode.
REQ-007 SHALL have port clk, input, 1, clock; all logic on the rising edge.
REQ-008 SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-009 SHALL have port s_valid, input, 1, input beat valid.
REQ-010 SHALL have port s_ready, output, 1, engine accepts a beat.
REQ-011 SHALL have port s_data, input, 8*DATA_BYTES, beat data; byte 0 = s_data[7:0] is processed first.
REQ-012 SHALL have port s_keep, input, DATA_BYTES, byte enables; contiguous from bit 0.
REQ-013 SHALL have port s_last, input, 1, final beat of the frame.
REQ-014 SHALL have port s_abort, input, 1, discards the frame in progress.
REQ-015 SHALL have port mode, input, 1, 0 = generate, 1 = check.
REQ-016 SHALL have port res_valid, output, 1, result strobe (one cycle).
REQ-017 SHALL have port res_crc, output, 32, final CRC, equal to register XOR XOROUT.
REQ-018 SHALL have port res_ok, output, 1, check passed; forced to 0 in generate mode.
REQ-019 SHALL have port busy, output, 1, frame in progress (state is not IDLE).

Function
REQ-020 SHALL implement FSM states IDLE, RUN and DONE.
REQ-021 SHALL define a beat as accepted when s_valid && s_ready; s_ready SHALL be 1 in IDLE and RUN and 0 in DONE.
REQ-022 SHALL, on a beat accepted in IDLE, seed the register from INIT, fold in that beat, latch mode for the whole frame, and go to RUN, or to DONE if s_last is set.
REQ-023 SHALL, on a beat accepted in RUN, fold in the kept bytes in ascending byte order within one cycle, and go to DONE if s_last is set.
REQ-024 SHALL leave the register unchanged on an accepted beat with s_keep all zero; s_last on such a beat still ends the frame.
REQ-025 SHALL, when s_keep is non-contiguous, process only the bytes below the lowest zero bit.
REQ-026 SHALL, in DONE, assert res_valid for exactly one cycle with res_crc and res_ok, then return to IDLE; result latency is 1 cycle after the last beat is accepted.
REQ-027 SHALL hold res_crc and res_ok stable until the next res_valid; res_ok = latched mode && (register == RESIDUE).
REQ-028 SHALL, on s_abort in RUN (priority over a simultaneous beat), go to IDLE with no res_valid.
REQ-029 SHALL ignore s_abort in IDLE and DONE.
REQ-030 SHALL allow back-to-back frames: there is a one-cycle gap (DONE) between the last beat and the first beat of the next frame.
REQ-031 SHALL compute all arithmetic modulo 2 on 32 bits, with no carries.

Reset
REQ-032 SHALL, while rst is high, set: state = IDLE, register = INIT, res_valid = 0, res_crc = 0, res_ok = 0, busy = 0, s_ready = 0.
REQ-033 SHALL, on rst mid-frame, discard the frame with no res_valid; the first cycle after reset is IDLE with s_ready = 1.

Structure
REQ-034 SHALL define the state encoding and the Ethernet polynomial, init, xorout and residue constants in shared package crc_pkg.
REQ-035 SHALL use sub-module crc_byte_step: combinational, one byte in, 32-bit register in/out, parameterised by POLY and REFLECT, instantiated DATA_BYTES times in a chain.

Verification
REQ-036 SHALL cover: DATA_BYTES=1, defaults, "123456789" in generate mode -> res_valid one cycle after the '9' beat, res_crc = 32'hCBF43926, res_ok = 0.
REQ-037 SHALL cover: DATA_BYTES=4, the same nine bytes sent as 3 beats with last s_keep = 4'b0001 -> res_crc = 32'hCBF43926.
REQ-038 SHALL cover: check mode, "123456789" followed by bytes 26 39 F4 CB -> res_ok = 1; flipping any one bit -> res_ok = 0.
REQ-039 SHALL cover: REFLECT=0, XOROUT=0 (CRC-32/MPEG-2), "123456789" -> res_crc = 32'h0376E6E7.
REQ-040 SHALL cover: s_abort mid-frame, then rst mid-frame -> no res_valid; the following frame gives the correct CRC.
REQ-041 SHALL cover: s_valid held high across two frames -> s_ready = 0 for exactly one cycle (DONE); both CRCs correct; an all-zero s_keep beat leaves the CRC unchanged.
